// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin access to one shared signed multiplier.
// One operation at a time: grant in IDLE, multiply in MUL, hold result in DONE.
module mult_share_arbiter #(
   parameter int N    = 5,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*N-1:0]   req_a,
   input  logic [NREQ*N-1:0]   req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [2*N-1:0]      res_out,
   output logic [IDW-1:0]      res_id,
   output logic                busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int unsigned NR = NREQ;

   logic [1:0]     state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] id_reg;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] next_ptr;
   logic           found;
   logic [N-1:0]   a_reg;
   logic [N-1:0]   b_reg;
   logic [2*N-1:0] a_ext;
   logic [2*N-1:0] b_ext;
   logic [2*N-1:0] product;

   // Shared multiplier: sign-extend to 2N bits; the low 2N bits of the
   // unsigned product are the exact two's-complement signed product.
   assign a_ext   = {{N{a_reg[N-1]}}, a_reg};
   assign b_ext   = {{N{b_reg[N-1]}}, b_reg};
   assign product = a_ext * b_ext;

   assign busy = (state != IDLE);

   // Round-robin search: first set request at or after rr_ptr, wrapping modulo NREQ
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NR) idx = idx - NR;
         if (!found && req_valid[IDW'(idx)]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
      next_ptr = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
   end

   // Grant pulse is combinational and only ever issued from IDLE
   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[winner] = 1'b1;
   end

   // Control FSM plus operand and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         id_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_valid <= 1'b0;
         res_out   <= '0;
         res_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  a_reg  <= req_a[winner*N +: N];
                  b_reg  <= req_b[winner*N +: N];
                  id_reg <= winner;
                  rr_ptr <= next_ptr;
                  state  <= MUL;
               end
            end
            MUL: begin
               res_out   <= product;
               res_id    <= id_reg;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (N=5, NREQ=4, IDW=2).
module tb_mult_share_arbiter;

   localparam int N    = 5;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*N-1:0]   req_a;
   logic [NREQ*N-1:0]   req_b;
   logic [NREQ-1:0]     req_ready;
   logic                res_valid;
   logic                res_ready;
   logic [2*N-1:0]      res_out;
   logic [IDW-1:0]      res_id;
   logic                busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NREQ*N-1:0] a_all;
   logic [NREQ*N-1:0] b_all;
   logic [2*N-1:0]    held_out;

   mult_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_id    (res_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // place a 5-bit value into requester slot i
   function automatic logic [NREQ*N-1:0] pk(input int i, input logic [N-1:0] v);
      logic [NREQ*N-1:0] r;
      r = '0;
      r[i*N +: N] = v;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one full operation with res_ready high; req_valid stays held throughout
   task automatic op(input string tag, input logic [NREQ-1:0] v,
                     input logic [NREQ*N-1:0] a, input logic [NREQ*N-1:0] b,
                     input int id, input logic [2*N-1:0] prod);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      res_ready = 1'b1;
      #1;
      check({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      step();
      check({tag, "_mul_rdy"}, 32'(req_ready), 32'd0);
      check({tag, "_mul_busy"}, 32'(busy), 32'd1);
      check({tag, "_mul_vld"}, 32'(res_valid), 32'd0);
      step();
      check({tag, "_vld"}, 32'(res_valid), 32'd1);
      check({tag, "_out"}, 32'(res_out), 32'(prod));
      check({tag, "_id"}, 32'(res_id), 32'(id));
      step();
      check({tag, "_acc_vld"}, 32'(res_valid), 32'd0);
      check({tag, "_acc_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;
      a_all     = pk(0, 5'd1) | pk(1, 5'd2) | pk(2, 5'd3) | pk(3, 5'd4);
      b_all     = pk(0, 5'd2) | pk(1, 5'd3) | pk(2, 5'd4) | pk(3, 5'd5);
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_out", 32'(res_out), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #1 rst = 1'b0;
      step();

      // 3 * -5 = -15
      op("t1", 4'b0001, pk(0, 5'd3), pk(0, 5'h1B), 0, 10'h3F1);

      // edge products on requester 2 (pointer now 1, first hit is 2)
      op("t2a", 4'b0100, pk(2, 5'h10), pk(2, 5'h10), 2, 10'h100);
      op("t2b", 4'b0100, pk(2, 5'h10), pk(2, 5'h0F), 2, 10'h310);
      op("t2c", 4'b0100, pk(2, 5'h00), pk(2, 5'h10), 2, 10'h000);
      req_valid = '0;

      // reset to bring the pointer back to 0
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;

      // all four requesting: order 0,1,2,3,0
      op("t3_0", 4'b1111, a_all, b_all, 0, 10'd2);
      op("t3_1", 4'b1111, a_all, b_all, 1, 10'd6);
      op("t3_2", 4'b1111, a_all, b_all, 2, 10'd12);
      op("t3_3", 4'b1111, a_all, b_all, 3, 10'd20);
      op("t3_4", 4'b1111, a_all, b_all, 0, 10'd2);

      // back-pressure: -7 * 6 = -42 on requester 1 (pointer is 1)
      req_valid = 4'b0010;
      req_a     = pk(1, 5'h19);
      req_b     = pk(1, 5'h06);
      res_ready = 1'b0;
      #1;
      check("t4_grant", 32'(req_ready), 32'b0010);
      step();
      req_valid = 4'b1111;
      req_a     = a_all;
      req_b     = b_all;
      step();
      held_out = 10'h3D6;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_vld", 32'(res_valid), 32'd1);
         check("t4_hold_out", 32'(res_out), 32'(held_out));
         check("t4_hold_id", 32'(res_id), 32'd1);
         check("t4_hold_rdy", 32'(req_ready), 32'd0);
         check("t4_hold_busy", 32'(busy), 32'd1);
         step();
      end
      res_ready = 1'b1;
      step();
      check("t4_acc_vld", 32'(res_valid), 32'd0);
      check("t4_next_grant", 32'(req_ready), 32'b0100);
      step();
      step();
      check("t4_next_out", 32'(res_out), 32'd12);
      check("t4_next_id", 32'(res_id), 32'd2);
      req_valid = '0;
      step();
      check("t4_idle_busy", 32'(busy), 32'd0);

      // async reset while result is held in DONE
      req_valid = 4'b1000;
      res_ready = 1'b0;
      step();
      req_valid = '0;
      step();
      check("t5_pre_vld", 32'(res_valid), 32'd1);
      check("t5_pre_out", 32'(res_out), 32'd20);
      rst = 1'b1;
      #1;
      check("t5_rst_vld", 32'(res_valid), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      op("t5_r2", 4'b0100, pk(2, 5'd5), pk(2, 5'd5), 2, 10'd25);
      // pointer must be 3, so requester 3 beats requester 0
      op("t5_ptr", 4'b1001, a_all, b_all, 3, 10'd20);

      // withdrawal: request raised in MUL, dropped before IDLE
      req_valid = 4'b0001;
      req_a     = a_all;
      req_b     = b_all;
      res_ready = 1'b1;
      #1;
      check("t6_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = 4'b0010;
      step();
      check("t6_done_id", 32'(res_id), 32'd0);
      req_valid = '0;
      step();
      check("t6_idle_rdy", 32'(req_ready), 32'd0);
      check("t6_idle_busy", 32'(busy), 32'd0);
      step();
      check("t6_stay_busy", 32'(busy), 32'd0);
      check("t6_stay_vld", 32'(res_valid), 32'd0);
      // pointer advanced only by the real grant to 0, so 1 wins over 0
      op("t6_ptr", 4'b0011, a_all, b_all, 1, 10'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
